// File: rtl/spike_word_packer.sv
// ============================================================================
// spike_word_packer
// ----------------------------------------------------------------------------
// Transmit side of a synaptic-array sparse-spike input port. A neuron layer
// delivers one fire bit per cycle in neuron-index order. The bits are packed
// LSB-first into 32-bit sparse bitmaps. Each finished bitmap is offered
// downstream on a valid/ready handshake.
//
// Optional feature macro: SPK_POPCNT_EN
//   When this macro is defined, the sb_popcnt port is added. It carries the
//   number of set bits in sparse_bits and is registered together with the
//   word.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   spk_valid    in   1      fire bit valid
//   spk_fire     in   1      1 = neuron at current index fired
//   spk_last     in   1      current neuron ends the timestep early
//   spk_ready    out  1      packer accepts spk_* this cycle
//   sparse_bits  out  32     packed word, bit n = neuron 32*sb_widx + n
//   sb_valid     out  1      sparse_bits valid
//   sb_ready     in   1      downstream accepts the word
//   sb_last      out  1      word is the final word of the frame
//   sb_widx      out  WIDXW  word index within the frame
//   sb_popcnt    out  6      set-bit count of sparse_bits (SPK_POPCNT_EN only)
// ============================================================================
module spike_word_packer #(
    parameter int NNEURON = 128,
    parameter int WIDXW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spk_valid,
    input  logic             spk_fire,
    input  logic             spk_last,
    output logic             spk_ready,
    output logic [31:0]      sparse_bits,
    output logic             sb_valid,
    input  logic             sb_ready,
    output logic             sb_last,
    output logic [WIDXW-1:0] sb_widx
`ifdef SPK_POPCNT_EN
    ,
    output logic [5:0]       sb_popcnt
`endif
);

    localparam int              NWORDS   = NNEURON / 32;
    localparam logic [WIDXW-1:0] LASTWIDX = WIDXW'(NWORDS - 1);

    // Accumulator for the word being built, and the word-held-back flag
    logic [31:0]      acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             pendLast_q, pendLast_d;
    logic [WIDXW-1:0] frameWidx_q, frameWidx_d;

    // Output buffer presented on the sb_* side
    logic [31:0]      obuf_q, obuf_d;
    logic             obufValid_q, obufValid_d;
    logic             obufLast_q, obufLast_d;
    logic [WIDXW-1:0] obufWidx_q, obufWidx_d;

    logic             accept;
    logic             implicitLast;
    logic             wordLast;
    logic             complete;
    logic             obufFree;
    logic [31:0]      merged;
    logic             loadEn;
    logic [31:0]      loadWord;
    logic             loadLast;

`ifdef SPK_POPCNT_EN
    logic [5:0]       obufPop_q, obufPop_d;

    function automatic logic [5:0] popCount(input logic [31:0] w);
        logic [5:0] s;
        s = 6'd0;
        for (int i = 0; i < 32; i++) begin
            s = s + {5'd0, w[i]};
        end
        return s;
    endfunction
`endif

    // Handshake qualifiers and word-completion detection. Because NNEURON is
    // a multiple of 32, the implicit frame end always falls on bit 31 of the
    // last word. The incoming bit is OR'd into acc, whose upper bits are
    // still zero from the last clear, so a short word is zero-padded.
    always_comb begin
        accept       = spk_valid & ~pend_q;
        implicitLast = (cnt_q == 5'd31) && (frameWidx_q == LASTWIDX);
        wordLast     = spk_last | implicitLast;
        complete     = accept & ((cnt_q == 5'd31) | wordLast);
        obufFree     = ~obufValid_q | sb_ready;
        merged       = spk_fire ? (acc_q | (32'd1 << cnt_q)) : acc_q;
    end

    // Next-state logic. A pending word has priority, and spikes are refused
    // while it is held. A completion that meets a free or draining buffer
    // loads on the same edge, so back-to-back words have no bubble.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pendLast_d  = pendLast_q;
        frameWidx_d = frameWidx_q;
        obuf_d      = obuf_q;
        obufValid_d = obufValid_q;
        obufLast_d  = obufLast_q;
        obufWidx_d  = obufWidx_q;
        loadEn      = 1'b0;
        loadWord    = merged;
        loadLast    = wordLast;

        if (pend_q) begin
            if (obufFree) begin
                loadEn   = 1'b1;
                loadWord = acc_q;
                loadLast = pendLast_q;
                pend_d   = 1'b0;
                acc_d    = 32'd0;
                cnt_d    = 5'd0;
            end
        end else if (accept) begin
            if (complete) begin
                if (obufFree) begin
                    loadEn = 1'b1;
                    acc_d  = 32'd0;
                    cnt_d  = 5'd0;
                end else begin
                    acc_d      = merged;
                    pend_d     = 1'b1;
                    pendLast_d = wordLast;
                end
            end else begin
                acc_d = merged;
                cnt_d = cnt_q + 5'd1;
            end
        end

        if (loadEn) begin
            obuf_d      = loadWord;
            obufValid_d = 1'b1;
            obufLast_d  = loadLast;
            obufWidx_d  = frameWidx_q;
            frameWidx_d = loadLast ? '0 : frameWidx_q + WIDXW'(1);
        end else if (obufValid_q & sb_ready) begin
            obufValid_d = 1'b0;
        end
    end

`ifdef SPK_POPCNT_EN
    // The count is taken from the word being loaded. It therefore updates
    // on the same edge as sparse_bits.
    always_comb begin
        obufPop_d = obufPop_q;
        if (loadEn) begin
            obufPop_d = popCount(loadWord);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obufPop_q <= 6'd0;
        end else begin
            obufPop_q <= obufPop_d;
        end
    end

    assign sb_popcnt = obufPop_q;
`endif

    // State registers. Reset discards any partial or pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= 32'd0;
            cnt_q       <= 5'd0;
            pend_q      <= 1'b0;
            pendLast_q  <= 1'b0;
            frameWidx_q <= '0;
            obuf_q      <= 32'd0;
            obufValid_q <= 1'b0;
            obufLast_q  <= 1'b0;
            obufWidx_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pendLast_q  <= pendLast_d;
            frameWidx_q <= frameWidx_d;
            obuf_q      <= obuf_d;
            obufValid_q <= obufValid_d;
            obufLast_q  <= obufLast_d;
            obufWidx_q  <= obufWidx_d;
        end
    end

    // Ready depends only on the held-word flag, so it never reacts
    // combinationally to the spike inputs.
    assign spk_ready   = ~pend_q;
    assign sparse_bits = obuf_q;
    assign sb_valid    = obufValid_q;
    assign sb_last     = obufLast_q;
    assign sb_widx     = obufWidx_q;

endmodule

// File: tb/tb_spike_word_packer.sv
// ============================================================================
// tb_spike_word_packer
// ----------------------------------------------------------------------------
// Directed bench for spike_word_packer, using the default NNEURON=128 frame.
// Inputs change on the falling edge and outputs are sampled there as well.
// A monitor records every sb handshake on the rising edge. The recorded words
// are compared against a hand-built list of expected words.
// ============================================================================
module tb_spike_word_packer;

    logic        clk;
    logic        rst_n;
    logic        spk_valid;
    logic        spk_fire;
    logic        spk_last;
    logic        spk_ready;
    logic [31:0] sparse_bits;
    logic        sb_valid;
    logic        sb_ready;
    logic        sb_last;
    logic [1:0]  sb_widx;
`ifdef SPK_POPCNT_EN
    logic [5:0]  sb_popcnt;
`endif

    int compared;
    int mismatched;

    logic [31:0] gotBits[$];
    logic        gotLast[$];
    logic [1:0]  gotWidx[$];
    logic [31:0] expBits[$];
    logic        expLast[$];
    logic [1:0]  expWidx[$];

    spike_word_packer #(
        .NNEURON(128),
        .WIDXW  (2)
    ) dut (
`ifdef SPK_POPCNT_EN
        .sb_popcnt  (sb_popcnt),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .spk_valid  (spk_valid),
        .spk_fire   (spk_fire),
        .spk_last   (spk_last),
        .spk_ready  (spk_ready),
        .sparse_bits(sparse_bits),
        .sb_valid   (sb_valid),
        .sb_ready   (sb_ready),
        .sb_last    (sb_last),
        .sb_widx    (sb_widx)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture every word that completes a handshake
    always @(posedge clk) begin
        if (rst_n && sb_valid && sb_ready) begin
            gotBits.push_back(sparse_bits);
            gotLast.push_back(sb_last);
            gotWidx.push_back(sb_widx);
        end
    end

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one fire bit and wait until it is accepted. The wait is bounded.
    task automatic applyStimulus(input logic fire, input logic last);
        int waited;
        waited    = 0;
        spk_valid = 1'b1;
        spk_fire  = fire;
        spk_last  = last;
        while (!spk_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!spk_ready) begin
            checkOutput("spkReadyTimeout", {31'd0, spk_ready}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        spk_valid = 1'b0;
        spk_fire  = 1'b0;
        spk_last  = 1'b0;
    endtask

    // Stream n fire bits taken LSB-first from a pattern
    task automatic sendWord(input logic [31:0] bits, input int n, input logic lastAtEnd);
        for (int i = 0; i < n; i++) begin
            applyStimulus(bits[i], lastAtEnd && (i == n - 1));
        end
    endtask

    task automatic expectWord(input logic [31:0] bits, input logic last, input logic [1:0] widx);
        expBits.push_back(bits);
        expLast.push_back(last);
        expWidx.push_back(widx);
    endtask

    initial begin
        int n;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        spk_valid  = 1'b0;
        spk_fire   = 1'b0;
        spk_last   = 1'b0;
        sb_ready   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstValid", {31'd0, sb_valid}, 32'd0);
        checkOutput("rstBits", sparse_bits, 32'd0);
        checkOutput("rstLast", {31'd0, sb_last}, 32'd0);
        checkOutput("rstWidx", {30'd0, sb_widx}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstSpkReady", {31'd0, spk_ready}, 32'd1);

        // A single word with fires at bits 0, 5 and 31
        sendWord(32'h80000021, 32, 1'b0);
        expectWord(32'h80000021, 1'b0, 2'd0);
        checkOutput("t1Valid", {31'd0, sb_valid}, 32'd1);
        checkOutput("t1Bits", sparse_bits, 32'h80000021);
        checkOutput("t1Widx", {30'd0, sb_widx}, 32'd0);
        checkOutput("t1Last", {31'd0, sb_last}, 32'd0);

        // Rest of the 128-neuron frame; the implicit last marks word 3
        sendWord(32'h12345678, 32, 1'b0);
        expectWord(32'h12345678, 1'b0, 2'd1);
        sendWord(32'hDEADBEEF, 32, 1'b0);
        expectWord(32'hDEADBEEF, 1'b0, 2'd2);
        sendWord(32'h0F0F00F1, 32, 1'b0);
        expectWord(32'h0F0F00F1, 1'b1, 2'd3);
        checkOutput("t2Last", {31'd0, sb_last}, 32'd1);

        // Early frame end at neuron 40, with fires at 33 and 40
        sendWord(32'h00000000, 32, 1'b0);
        expectWord(32'h00000000, 1'b0, 2'd0);
        sendWord(32'h00000102, 9, 1'b1);
        expectWord(32'h00000102, 1'b1, 2'd1);
        checkOutput("t3Bits", sparse_bits, 32'h00000102);
        checkOutput("t3Last", {31'd0, sb_last}, 32'd1);
        sendWord(32'h00000001, 32, 1'b0);
        expectWord(32'h00000001, 1'b0, 2'd0);
        checkOutput("t3Restart", sparse_bits, 32'h00000001);

        // Backpressure: one word sits in the buffer and a second is pending
        @(negedge clk);
        sb_ready = 1'b0;
        sendWord(32'hA5A5A5A5, 32, 1'b0);
        expectWord(32'hA5A5A5A5, 1'b0, 2'd1);
        sendWord(32'h0000FFFF, 32, 1'b0);
        expectWord(32'h0000FFFF, 1'b0, 2'd2);
        checkOutput("t4SpkReadyLow", {31'd0, spk_ready}, 32'd0);
        checkOutput("t4HeldValid", {31'd0, sb_valid}, 32'd1);
        checkOutput("t4HeldBits", sparse_bits, 32'hA5A5A5A5);
        @(negedge clk);
        checkOutput("t4StillHeld", sparse_bits, 32'hA5A5A5A5);
        sb_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4SecondBits", sparse_bits, 32'h0000FFFF);
        checkOutput("t4SecondValid", {31'd0, sb_valid}, 32'd1);
        checkOutput("t4SpkReadyBack", {31'd0, spk_ready}, 32'd1);

        // Reset part-way through a word, asserted between clock edges
        sendWord(32'h000003FF, 10, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5AsyncBits", sparse_bits, 32'd0);
        checkOutput("t5AsyncWidx", {30'd0, sb_widx}, 32'd0);
        checkOutput("t5AsyncValid", {31'd0, sb_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sendWord(32'hCAFEF00D, 32, 1'b0);
        expectWord(32'hCAFEF00D, 1'b0, 2'd0);
        checkOutput("t5Bits", sparse_bits, 32'hCAFEF00D);

        // spk_last on bit 31 yields one word only
        sendWord(32'h13579BDF, 32, 1'b1);
        expectWord(32'h13579BDF, 1'b1, 2'd1);
        sendWord(32'h00000080, 32, 1'b0);
        expectWord(32'h00000080, 1'b0, 2'd0);

`ifdef SPK_POPCNT_EN
        // Population count for a full word and for a padded last word
        sendWord(32'hFFFFFFFF, 32, 1'b0);
        expectWord(32'hFFFFFFFF, 1'b0, 2'd1);
        checkOutput("t6PopFull", {26'd0, sb_popcnt}, 32'd32);
        sendWord(32'h00000015, 5, 1'b1);
        expectWord(32'h00000015, 1'b1, 2'd2);
        checkOutput("t6PopPad", {26'd0, sb_popcnt}, 32'd3);
`endif

        // Allow the last word to drain, then compare the recorded stream
        repeat (5) @(negedge clk);
        checkOutput("wordCount", gotBits.size(), expBits.size());
        n = (gotBits.size() < expBits.size()) ? gotBits.size() : expBits.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("word%0dBits", i), gotBits[i], expBits[i]);
            checkOutput($sformatf("word%0dLast", i), {31'd0, gotLast[i]}, {31'd0, expLast[i]});
            checkOutput($sformatf("word%0dWidx", i), {30'd0, gotWidx[i]}, {30'd0, expWidx[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
